melody_sequencer: RTL

Playback controller for the speaker path. Steps a 6-bit address through the combinational song ROM at a tempo set by an external tick enable and handles play, pause and stop commands. Inserts an articulation gap at the end of each step, supports one-shot or looped playback, and presents a registered 20-bit half-period value plus a tone enable to the square-wave tone generator. A ROM value of 0 means rest.

---
 rtl/melody_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Melody playback controller: walks a song ROM one step per SUB_PER_STEP tempo ticks,
// handles play/pause/stop, and drives a registered half-period plus tone enable.
module melody_sequencer #(
    parameter int ADDR_W       = 6,
    parameter int LAST_STEP    = 63,
    parameter int SUB_PER_STEP = 4,
    parameter int GAP_SUB      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop,
    input  logic              legato,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [19:0]       rom_note,
    output logic [19:0]       note_div,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);

    localparam int SUB_W = $clog2(SUB_PER_STEP);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_PER_STEP - 1);
    // One extra bit so GAP_SUB=0 yields a threshold no sub value can reach.
    localparam logic [SUB_W:0]    GAP_START = (SUB_W + 1)'(SUB_PER_STEP - GAP_SUB);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSED
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [SUB_W-1:0]  sub_reg,   sub_next;
    logic              done_reg,  done_next;
    logic [19:0]       note_reg,  note_next;
    logic              tone_reg,  tone_next;
    logic              gap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            sub_reg   <= '0;
            done_reg  <= 1'b0;
            note_reg  <= '0;
            tone_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            sub_reg   <= sub_next;
            done_reg  <= done_next;
            note_reg  <= note_next;
            tone_reg  <= tone_next;
        end
    end

    // Commands in priority order; an applicable command swallows a coincident tick.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        sub_next   = sub_reg;
        done_next  = 1'b0;
        if (stop && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
            addr_next  = '0;
            sub_next   = '0;
        end else if (pause && state_reg == ST_PLAY) begin
            state_next = ST_PAUSED;
        end else if (play && state_reg == ST_IDLE) begin
            state_next = ST_PLAY;
            addr_next  = '0;
            sub_next   = '0;
        end else if (play && state_reg == ST_PAUSED) begin
            state_next = ST_PLAY;
        end else if (tick && state_reg == ST_PLAY) begin
            if (sub_reg < SUB_LAST) begin
                sub_next = sub_reg + 1'b1;
            end else begin
                sub_next = '0;
                if (addr_reg < LAST_ADDR) begin
                    addr_next = addr_reg + 1'b1;
                end else begin
                    addr_next = '0;
                    if (!loop) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
        end
    end

    // Output stage sees the ROM value for the current address, hence the one-cycle lag.
    always_comb begin
        gap       = !legato && ({1'b0, sub_reg} >= GAP_START);
        note_next = '0;
        if (state_reg == ST_PLAY && !gap) begin
            note_next = rom_note;
        end
        tone_next = |note_next;
    end

    assign rom_addr = addr_reg;
    assign note_div = note_reg;
    assign tone_en  = tone_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;

endmodule
